// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers beam position from active-low hs/vs,
// measures line/frame length and sync widths, and reports lock on stable timing.
module vga_sync_monitor #(
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT_W   = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [HW-1:0] h_total,
  output logic [VW-1:0] v_total,
  output logic [HW-1:0] h_pw,
  output logic [VW-1:0] v_pw,
  output logic          locked,
  output logic          timing_err
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;
  // The latched reference frame is the first of the LOCK_FRAMES identical frames.
  localparam logic [3:0] LOCK_N = (LOCK_FRAMES > 1) ? 4'(LOCK_FRAMES - 1) : 4'd1;

  state_e         state_q;
  logic           hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, hs_prev_q, vs_prev_q;
  logic [HW-1:0]  x_q, h_total_q, h_pw_q;
  logic [VW-1:0]  y_q, v_total_q, v_pw_q, vcnt_q;
  logic           vpend_q, bad_q, line_start_q, frame_start_q, locked_q, timing_err_q;
  logic [3:0]     match_q;
  logic [TIMEOUT_W-1:0] to_q;

  logic          hs_fall, hs_rise, vs_fall, timeout, h_mis, v_match;
  logic [HW-1:0] len;
  logic [VW-1:0] flen;
  logic [3:0]    match_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q <= 1'b1; hs_s2_q <= 1'b1; vs_s1_q <= 1'b1; vs_s2_q <= 1'b1;
    end else begin
      hs_s1_q <= hs_in; hs_s2_q <= hs_s1_q;
      vs_s1_q <= vs_in; vs_s2_q <= vs_s1_q;
    end
  end

  assign hs_fall = pix_en &  hs_prev_q & ~hs_s2_q;
  assign hs_rise = pix_en & ~hs_prev_q &  hs_s2_q;
  assign vs_fall = pix_en &  vs_prev_q & ~vs_s2_q;
  assign timeout = pix_en & ~hs_fall & (&to_q);
  assign len     = (x_q == HMAX) ? HMAX : x_q + 1'b1;
  assign flen    = (y_q == VMAX) ? VMAX : y_q + 1'b1;
  assign h_mis   = hs_fall && (len != h_total_q);
  assign v_match = (flen == v_total_q) && !bad_q && !h_mis;
  assign match_d = match_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      hs_prev_q <= 1'b1; vs_prev_q <= 1'b1;
      x_q <= '0; y_q <= '0; h_total_q <= '0; v_total_q <= '0;
      h_pw_q <= '0; v_pw_q <= '0; vcnt_q <= '0; vpend_q <= 1'b0;
      bad_q <= 1'b0; match_q <= '0; to_q <= '0;
      line_start_q <= 1'b0; frame_start_q <= 1'b0;
      locked_q <= 1'b0; timing_err_q <= 1'b0;
    end else begin
      line_start_q  <= hs_fall;
      frame_start_q <= vs_fall;
      timing_err_q  <= 1'b0;
      if (pix_en) begin
        hs_prev_q <= hs_s2_q;
        vs_prev_q <= vs_s2_q;
        if (hs_fall)             x_q <= '0;
        else if (x_q != HMAX)    x_q <= x_q + 1'b1;
        if (hs_rise)             h_pw_q <= len;
        if (vs_fall)             y_q <= '0;
        else if (hs_fall && y_q != VMAX) y_q <= y_q + 1'b1;
        // Sync-low lines are counted on hs falls; the count is published once vs is back high.
        if (hs_fall) begin
          if (!vs_s2_q)          vcnt_q <= vs_fall ? VW'(1) : ((vcnt_q == VMAX) ? VMAX : vcnt_q + 1'b1);
          else if (vpend_q) begin
            v_pw_q  <= vcnt_q;
            vpend_q <= 1'b0;
          end
        end else if (vs_fall)    vcnt_q <= '0;
        if (vs_fall)             vpend_q <= 1'b1;
        to_q <= hs_fall ? '0 : to_q + 1'b1;

        if (timeout) begin
          timing_err_q <= (state_q == LOCKED);
          state_q   <= SEARCH;
          locked_q  <= 1'b0;
          h_total_q <= '0;
          v_total_q <= '0;
          match_q   <= '0;
          bad_q     <= 1'b0;
        end else begin
          case (state_q)
            SEARCH: if (vs_fall) begin
              state_q <= ACQUIRE;
              match_q <= '0;
              bad_q   <= 1'b0;
            end
            ACQUIRE: begin
              if (h_mis) begin
                h_total_q <= len;
                match_q   <= '0;
                bad_q     <= 1'b1;
              end
              if (vs_fall) begin
                bad_q <= 1'b0;
                if (v_match) begin
                  match_q <= match_d;
                  if (match_d >= LOCK_N) begin
                    state_q  <= LOCKED;
                    locked_q <= 1'b1;
                  end
                end else begin
                  v_total_q <= flen;
                  match_q   <= '0;
                end
              end
            end
            LOCKED: if (h_mis || (vs_fall && flen != v_total_q)) begin
              timing_err_q <= 1'b1;
              locked_q     <= 1'b0;
              state_q      <= ACQUIRE;
              match_q      <= '0;
              if (h_mis)                        h_total_q <= len;
              if (vs_fall && flen != v_total_q) v_total_q <= flen;
              // A bad line mid-frame disqualifies the rest of that frame.
              bad_q <= h_mis && !vs_fall;
            end
            default: state_q <= SEARCH;
          endcase
        end
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign h_pw        = h_pw_q;
  assign v_pw        = v_pw_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a compact 40x12 raster (hs low 6, vs low 2).
module tb_vga_sync_monitor;
  localparam int HW = 11, VW = 10;
  localparam int H = 40, HPW = 6, V = 12, VPW = 2;

  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [HW-1:0] x, h_total, h_pw;
  logic [VW-1:0] y, v_total, v_pw;
  logic line_start, frame_start, locked, timing_err;

  int checks = 0, errors = 0, div = 1;
  int fs_cnt, ls_cnt, err_cnt, lock_fs, coinc;
  logic [HW-1:0] x_last, x_pre;
  logic [VW-1:0] y_at_fs;
  logic lk_prev;

  vga_sync_monitor dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total), .h_pw(h_pw), .v_pw(v_pw),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  // Event recorder sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      fs_cnt <= 0; ls_cnt <= 0; err_cnt <= 0; lock_fs <= 0; coinc <= 0;
      x_last <= '0; x_pre <= '0; y_at_fs <= '1; lk_prev <= 1'b0;
    end else begin
      x_last  <= x;
      lk_prev <= locked;
      if (line_start)  begin ls_cnt <= ls_cnt + 1; x_pre <= x_last; end
      if (frame_start) begin fs_cnt <= fs_cnt + 1; y_at_fs <= y; end
      if (timing_err)  err_cnt <= err_cnt + 1;
      if (line_start && frame_start) coinc <= coinc + 1;
      if (locked && !lk_prev && lock_fs == 0) lock_fs <= fs_cnt + (frame_start ? 1 : 0);
    end
  end

  task automatic pixels(input int ln, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      hs_in = (i < HPW) ? 1'b0 : 1'b1;
      vs_in = (ln < VPW) ? 1'b0 : 1'b1;
      pix_en = 1'b1;
      @(negedge clk);
      for (int k = 1; k < div; k++) begin pix_en = 1'b0; @(negedge clk); end
    end
  endtask

  task automatic frame(input int short_ln);
    for (int ln = 0; ln < V; ln++) pixels(ln, 0, (ln == short_ln) ? H - 2 : H - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({x, y, h_total, v_total, h_pw, v_pw, line_start, frame_start, locked, timing_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got x=%0d y=%0d ht=%0d vt=%0d lk=%b want all 0", x, y, h_total, v_total, locked);
    end
    // With the strobe held low nothing may advance even though hs falls.
    hs_in = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (x !== '0 || ls_cnt != 0) begin
      errors++; $display("FAIL pix_en_low_hold: got x=%0d line_starts=%0d want 0 0", x, ls_cnt);
    end
    hs_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock();
    div = 1;
    do_reset();
    repeat (4) frame(-1);
    checks++; if (h_total !== 11'd40) begin errors++; $display("FAIL lock_h_total: got %0d want 40", h_total); end
    checks++; if (h_pw !== 11'd6)     begin errors++; $display("FAIL lock_h_pw: got %0d want 6", h_pw); end
    checks++; if (v_total !== 10'd12) begin errors++; $display("FAIL lock_v_total: got %0d want 12", v_total); end
    checks++; if (v_pw !== 10'd2)     begin errors++; $display("FAIL lock_v_pw: got %0d want 2", v_pw); end
    checks++; if (locked !== 1'b1 || lock_fs != 3) begin
      errors++; $display("FAIL lock_rise: got locked=%b at frame_start %0d want 1 at 3", locked, lock_fs);
    end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL lock_no_err: got %0d want 0", err_cnt); end
    checks++; if (y !== 10'd11 || x_pre !== 11'd39) begin
      errors++; $display("FAIL lock_position: got y=%0d x_before_fall=%0d want 11 39", y, x_pre);
    end
  endtask

  task automatic test_short_line();
    int e0;
    e0 = err_cnt;
    for (int ln = 0; ln < 6; ln++) pixels(ln, 0, (ln == 5) ? H - 2 : H - 1);
    pixels(6, 0, 9);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL short_err_pulse: got %0d want 1", err_cnt - e0); end
    checks++; if (locked !== 1'b0 || h_total !== 11'd39) begin
      errors++; $display("FAIL short_relatch: got locked=%b h_total=%0d want 0 39", locked, h_total);
    end
    pixels(6, 10, H - 1);
    for (int ln = 7; ln < V; ln++) pixels(ln, 0, H - 1);
    pixels(0, 0, 9);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short_dirty_frame: got locked=%b want 0", locked); end
    pixels(0, 10, H - 1);
    for (int ln = 1; ln < V; ln++) pixels(ln, 0, H - 1);
    frame(-1);
    pixels(0, 0, 9);
    checks++; if (locked !== 1'b1 || h_total !== 11'd40 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL short_relock: got locked=%b h_total=%0d errs=%0d want 1 40 1", locked, h_total, err_cnt - e0);
    end
    pixels(0, 10, H - 1);
    for (int ln = 1; ln < V; ln++) pixels(ln, 0, H - 1);
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    hs_in = 1'b1; vs_in = 1'b1; pix_en = 1'b1;
    repeat (4200) @(negedge clk);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
    checks++; if (locked !== 1'b0 || h_total !== '0 || v_total !== '0) begin
      errors++; $display("FAIL timeout_clear: got locked=%b ht=%0d vt=%0d want 0 0 0", locked, h_total, v_total);
    end
  endtask

  task automatic test_strobe_div();
    div = 4;
    do_reset();
    repeat (4) frame(-1);
    checks++; if (h_total !== 11'd40 || h_pw !== 11'd6) begin
      errors++; $display("FAIL div4_h: got ht=%0d hpw=%0d want 40 6", h_total, h_pw);
    end
    checks++; if (v_total !== 10'd12 || v_pw !== 10'd2) begin
      errors++; $display("FAIL div4_v: got vt=%0d vpw=%0d want 12 2", v_total, v_pw);
    end
    checks++; if (x_pre !== 11'd39 || locked !== 1'b1 || lock_fs != 3) begin
      errors++; $display("FAIL div4_x_lock: got x_before_fall=%0d locked=%b lock_fs=%0d want 39 1 3", x_pre, locked, lock_fs);
    end
  endtask

  task automatic test_midframe_reset();
    int l0;
    for (int ln = 0; ln < 4; ln++) pixels(ln, 0, H - 1);
    pixels(4, 0, 19);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x, y, h_total, v_total, h_pw, v_pw, line_start, frame_start, locked, timing_err} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got x=%0d y=%0d ht=%0d vt=%0d lk=%b want all 0", x, y, h_total, v_total, locked);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    l0 = ls_cnt;
    pixels(4, 20, H - 1);
    checks++; if (ls_cnt != l0) begin errors++; $display("FAIL midreset_no_line_start: got %0d want 0", ls_cnt - l0); end
  endtask

  task automatic test_coincident();
    div = 1;
    do_reset();
    repeat (2) frame(-1);
    checks++; if (coinc != 2 || fs_cnt != 2) begin
      errors++; $display("FAIL coincident_pulses: got together=%0d frames=%0d want 2 2", coinc, fs_cnt);
    end
    checks++; if (y_at_fs !== '0) begin errors++; $display("FAIL coincident_y: got %0d want 0", y_at_fs); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_timeout();
    test_strobe_div();
    test_midframe_reset();
    test_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
